// File: rtl/black_box_inverter.sv
// black_box_inverter: bit-wise inverter leaf cell with registered copy, input-change pulse and optional change counter
//
// Ports:
//   clock_i    system clock, all state updates on the rising edge
//   reset_i    synchronous active-high reset
//   in_i       data to invert (WIDTH bits)
//   out_o      combinational ~in_i, independent of clock and reset
//   out_q_o    registered ~in_i, all ones in reset
//   chg_o      registered pulse, high when in_i differs from the previous cycle's in_i
//   chg_cnt_o  saturating count of change pulses (CNT_W bits)
//
// Build option: define INV_STATS_EN to include the change counter; otherwise chg_cnt_o is tied to zero.
module black_box_inverter #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o,
    output logic [WIDTH-1:0] out_q_o,
    output logic             chg_o,
    output logic [CNT_W-1:0] chg_cnt_o
);
    logic [WIDTH-1:0] in_prev_q;
    logic [WIDTH-1:0] out_inv_q;
    logic [WIDTH-1:0] out_inv_d;
    logic             chg_q;
    logic             chg_d;
    logic             diff;

    assign out_o = ~in_i;
    assign diff  = in_i != in_prev_q;

    always_comb begin
        out_inv_d = ~in_i;
        chg_d     = diff;
    end

    // in_prev_q tracks in_i even in reset so the first post-reset cycle compares against the last reset-time input
    always_ff @(posedge clock_i) begin
        in_prev_q <= in_i;
        if (reset_i) begin
            out_inv_q <= '1;
            chg_q     <= 1'b0;
        end else begin
            out_inv_q <= out_inv_d;
            chg_q     <= chg_d;
        end
    end

    assign out_q_o = out_inv_q;
    assign chg_o   = chg_q;

`ifdef INV_STATS_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturate at all ones instead of wrapping
    assign cnt_d = (diff && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign chg_cnt_o = cnt_q;
`else
    assign chg_cnt_o = '0;
`endif
endmodule

// File: tb/tb_black_box_inverter.sv
// tb_black_box_inverter: randomized scoreboard bench for black_box_inverter (8-bit and 1-bit instances)
module tb_black_box_inverter;
    typedef struct {
        logic [7:0]  o8;
        logic [7:0]  q8;
        logic        c8;
        logic [2:0]  n8;
        logic        o1;
        logic        q1;
        logic        c1;
        logic [15:0] n1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in8;
    logic        in1;
    logic [7:0]  out8, outq8;
    logic        chg8;
    logic [2:0]  cnt8;
    logic        out1, outq1, chg1;
    logic [15:0] cnt1;

    exp_t        q[$];
    int          vec = 0;
    int          err = 0;
    logic [7:0]  p8;
    logic        p1;
    int          m8 = 0;
    int          m1 = 0;

    always #5 clk = ~clk;

    black_box_inverter #(.WIDTH(8), .CNT_W(3)) u8 (
        .clock_i(clk), .reset_i(rst), .in_i(in8),
        .out_o(out8), .out_q_o(outq8), .chg_o(chg8), .chg_cnt_o(cnt8)
    );

    black_box_inverter #(.WIDTH(1), .CNT_W(16)) u1 (
        .clock_i(clk), .reset_i(rst), .in_i(in1),
        .out_o(out1), .out_q_o(outq1), .chg_o(chg1), .chg_cnt_o(cnt1)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vec++;
        if (a !== e) begin
            err++;
            $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    // Reference: out is ~in now; after the edge out_q is ~in (or ones in reset),
    // chg flags a difference from the previous cycle's input, count is the number
    // of changes since reset clipped at the counter's maximum.
    task automatic step(input logic r, input logic [7:0] a, input logic b);
        exp_t e;
        @(negedge clk);
        rst = r;
        in8 = a;
        in1 = b;
        e.o8 = ~a;
        e.o1 = ~b;
        e.q8 = r ? 8'hFF : ~a;
        e.q1 = r ? 1'b1 : ~b;
        e.c8 = !r && (a != p8);
        e.c1 = !r && (b != p1);
`ifdef INV_STATS_EN
        m8 = r ? 0 : (e.c8 ? ((m8 + 1 > 7) ? 7 : m8 + 1) : m8);
        m1 = r ? 0 : (e.c1 ? ((m1 + 1 > 65535) ? 65535 : m1 + 1) : m1);
`else
        m8 = 0;
        m1 = 0;
`endif
        e.n8 = 3'(m8);
        e.n1 = 16'(m1);
        p8 = a;
        p1 = b;
        q.push_back(e);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("out8", 32'(out8), 32'(e.o8));
            chk("out_q8", 32'(outq8), 32'(e.q8));
            chk("chg8", 32'(chg8), 32'(e.c8));
            chk("cnt8", 32'(cnt8), 32'(e.n8));
            chk("out1", 32'(out1), 32'(e.o1));
            chk("out_q1", 32'(outq1), 32'(e.q1));
            chk("chg1", 32'(chg1), 32'(e.c1));
            chk("cnt1", 32'(cnt1), 32'(e.n1));
        end
    end

    initial begin
        logic [7:0] a;
        step(1'b1, 8'hA5, 1'b1);
        step(1'b1, 8'hA5, 1'b1);
        repeat (3) step(1'b0, 8'hA5, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        repeat (2) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 8'(i * 3 + 1), i[0]);
        step(1'b1, 8'($urandom), 1'($urandom));
        step(1'b0, 8'h3C, 1'b0);
        for (int i = 0; i < 80; i++) begin
            a = ($urandom_range(0, 2) == 0) ? p8 : 8'($urandom);
            step($urandom_range(0, 15) == 0, a, 1'($urandom));
        end
        for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            err++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/black_box_inverter.md
Name: black_box_inverter

Overview:
- Bit-wise inverter leaf cell, normally instantiated as an opaque (black-box) primitive; testers drive constants and check the inverted result.
- Primary output is purely combinational: out = ~in.
- Also provides a registered copy of the inverted value and an input-change pulse, clocked on the single system clock.

Parameters:
- WIDTH, 1, bit width of in/out/out_q.
- CNT_W, 16, width of the change counter; used only when INV_STATS_EN is defined.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  data to invert.
- out  output  WIDTH  combinational bit-wise inverse of in.
- out_q  output  WIDTH  registered bit-wise inverse of in.
- chg  output  1  registered pulse: in differed from previous cycle's in.
- chg_cnt  output  CNT_W  saturating count of chg pulses; all zeros when feature compiled out.

Behaviour:
- out = ~in for every bit, zero latency.
  - No clock or reset dependence; valid during reset.
  - Required results: in=1 gives out=0; in=0 gives out=1 (WIDTH=1).
- out_q register:
  - Each rising edge with reset=0: out_q <= ~in.
  - With reset=1: out_q <= all ones (the value ~0).
  - Latency 1 cycle relative to out.
- in_prev register (internal):
  - Each edge: in_prev <= in, including during reset.
  - This makes the first post-reset cycle compare against the last in seen in reset.
- chg register:
  - Edge with reset=0: chg <= (in != in_prev).
  - Edge with reset=1: chg <= 0.
  - Single-cycle pulse per change; held high while in keeps changing every cycle.
- Widths: all operations are bit-wise at WIDTH; no arithmetic on data.
- Reset values:
  - out_q = all ones.
  - chg = 0.
  - chg_cnt = 0.
  - out: not reset, always ~in.
- Reset mid-operation: registers take reset values on the next edge; out unaffected.
- X on in propagates to out and out_q; no masking.

Optional Feature:
- Macro INV_STATS_EN.
- Defined:
  - chg_cnt is a CNT_W-bit counter, cleared by reset.
  - Increments on each edge where reset=0 and in != in_prev.
  - Saturates at all-ones and never wraps.
- Not defined:
  - chg_cnt tied to all zeros.
  - No counter logic is synthesized.
  - Port list is unchanged.

Test Plan:
- WIDTH=1. Hold reset=1 for 2 cycles with in=1, release, keep in=1 -> out=0 every cycle; out_q=1 during reset, then 0 from the first post-reset edge.
- WIDTH=1, second instance with in=0 constant -> out=1 every cycle (also during reset); out_q=1; chg stays 0.
- WIDTH=8, in=8'hA5 -> out=8'h5A immediately; out_q=8'h5A after one edge. Then in=8'h00 -> out=8'hFF same cycle, out_q=8'hFF next edge, chg=1 for exactly one cycle.
- WIDTH=1, toggle in every cycle for 10 cycles after reset -> chg=1 each of those cycles. With INV_STATS_EN: chg_cnt=10. Without it: chg_cnt=0.
- CNT_W=2 with INV_STATS_EN, toggle in for 6 cycles -> chg_cnt saturates at 3 and holds. Assert reset for 1 cycle -> chg_cnt=0, chg=0, out_q=all ones, out still ~in.
